// File: rtl/prog_loader_mem.sv
// Writable program store: 1-cycle registered read port plus a beat-wise loader that fills every word in order.
// Contents are undefined until the first complete load; loader always present.
module prog_loader_mem #(
  parameter int Psize = 4,
  parameter int Csize = 12,
  parameter int Lsize = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [Psize-1:0] addr_i,
  input  logic             rd_en_i,
  output logic [Csize-1:0] controlWord_o,
  output logic             rd_valid_o,
  input  logic             load_start_i,
  input  logic [Lsize-1:0] load_data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic             load_busy_o,
  output logic             load_done_o
);

  localparam int NB    = (Csize + Lsize - 1) / Lsize;
  localparam int AW    = NB * Lsize;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 1 << Psize;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state_q;
  logic [Psize-1:0]   wptr_q;
  logic [BW-1:0]      bcnt_q;
  logic [AW-1:0]      asm_q, asm_d;
  logic [Csize-1:0]   cw_q;
  logic               rd_valid_q, ready_q, busy_q, done_q;
  logic               beat_acc, last_beat;

  logic [Csize-1:0]   mem [DEPTH];

  // ready_q is high exactly while in LOAD, so it doubles as the state qualifier
  assign beat_acc  = load_valid_i && ready_q;
  assign last_beat = beat_acc && (bcnt_q == BW'(NB - 1));

  always_comb begin
    asm_d = asm_q;
    if (beat_acc) asm_d[int'(bcnt_q) * Lsize +: Lsize] = load_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (last_beat && !reset_i) mem[wptr_q] <= asm_d[Csize-1:0];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      cw_q       <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_en_i) begin
            cw_q       <= mem[addr_i];
            rd_valid_q <= 1'b1;
          end
          if (load_start_i) begin
            state_q <= LOAD;
            wptr_q  <= '0;
            bcnt_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (beat_acc) asm_q <= asm_d;
          if (last_beat) begin
            bcnt_q <= '0;
            wptr_q <= wptr_q + 1'b1;
            if (wptr_q == {Psize{1'b1}}) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (beat_acc) begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign controlWord_o = cw_q;
  assign rd_valid_o    = rd_valid_q;
  assign load_ready_o  = ready_q;
  assign load_busy_o   = busy_q;
  assign load_done_o   = done_q;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Scoreboard bench for prog_loader_mem: reads push expected words, a negedge monitor pops on rd_valid.
module tb_prog_loader_mem;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        rd_en;
  logic [11:0] controlWord;
  logic        rd_valid;
  logic        load_start;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready, load_busy, load_done;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          done_cnt = 0;
  logic [11:0] model [DEPTH];
  logic [11:0] exp_q [$];
  logic [11:0] cw_hold = 12'h000;
  logic [11:0] mon_e;
  bit          ready_ok, hold_ok;

  prog_loader_mem #(.Psize(4), .Csize(12), .Lsize(8)) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .addr_i       (addr),
    .rd_en_i      (rd_en),
    .controlWord_o(controlWord),
    .rd_valid_o   (rd_valid),
    .load_start_i (load_start),
    .load_data_i  (load_data),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_busy_o  (load_busy),
    .load_done_o  (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
    if (rd_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("read_data", 32'(controlWord), 32'(mon_e));
        cw_hold = mon_e;
      end
    end
  end

  // mode 0: word 0xA00+i, mode 1: high beat 0xFF, mode 2: word 0x5C0+i
  function automatic logic [7:0] beat_val(input int mode, input int i, input int b);
    case (mode)
      0:       return (b != 0) ? 8'h0A : 8'(i);
      1:       return (b != 0) ? 8'hFF : 8'(i * 17);
      default: return (b != 0) ? 8'h05 : 8'(8'hC0 + i);
    endcase
  endfunction

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_en = 1'b1;
      addr  = 4'(a);
      exp_q.push_back(model[a]);
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int mode, input bit gap, input int abort_beats,
                         input bit rd_with_start, input logic [3:0] rd_addr);
    int         d0, nbeats, nwords;
    logic [7:0] lo, hi;
    d0       = done_cnt;
    ready_ok = 1'b1;
    hold_ok  = 1'b1;
    nbeats   = (abort_beats > 0) ? abort_beats : 32;
    load_start = 1'b1;
    if (rd_with_start) begin
      rd_en = 1'b1;
      addr  = rd_addr;
      exp_q.push_back(model[rd_addr]);
    end
    @(posedge clk); #1;
    load_start = 1'b0;
    rd_en      = 1'b0;
    chk("busy_after_start", 32'(load_busy), 32'd1);
    chk("ready_after_start", 32'(load_ready), 32'd1);
    for (int b = 0; b < nbeats; b++) begin
      load_valid = 1'b1;
      load_data  = beat_val(mode, b / 2, b % 2);
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      if (b < 31 && load_ready !== 1'b1) ready_ok = 1'b0;
      if (gap && b < nbeats - 1) begin
        rd_en      = 1'b1;
        load_start = 1'b1;
        addr       = 4'(b / 2);
        @(posedge clk); #1;
        rd_en      = 1'b0;
        load_start = 1'b0;
        if (load_ready !== 1'b1) ready_ok = 1'b0;
        if (controlWord !== cw_hold) hold_ok = 1'b0;
      end
    end
    chk("ready_held_in_load", 32'(ready_ok), 32'd1);
    if (gap) chk("cw_held_in_load", 32'(hold_ok), 32'd1);
    if (abort_beats == 0) begin
      chk("done_after_last_beat", 32'(load_done), 32'd1);
      chk("busy_in_done", 32'(load_busy), 32'd1);
      chk("ready_low_in_done", 32'(load_ready), 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(load_done), 32'd0);
      chk("busy_low_after_done", 32'(load_busy), 32'd0);
      chk("done_pulse_count", 32'(done_cnt - d0), 32'd1);
      nwords = DEPTH;
    end else begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cw_hold = 12'h000;
      chk("abort_busy", 32'(load_busy), 32'd0);
      chk("abort_ready", 32'(load_ready), 32'd0);
      chk("abort_cw_reset", 32'(controlWord), 32'd0);
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      nwords = abort_beats / 2;
    end
    for (int i = 0; i < nwords; i++) begin
      lo = beat_val(mode, i, 0);
      hi = beat_val(mode, i, 1);
      model[i] = {hi[3:0], lo};
    end
  endtask

  initial begin
    reset      = 1'b1;
    rd_en      = 1'b1;
    addr       = 4'd0;
    load_start = 1'b0;
    load_data  = 8'h00;
    load_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 12'h000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_cw", 32'(controlWord), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_ready", 32'(load_ready), 32'd0);
    chk("reset_busy", 32'(load_busy), 32'd0);
    chk("reset_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    rd_en = 1'b0;
    @(posedge clk); #1;

    do_load(0, 1'b0, 0, 1'b0, 4'd0);
    rd_en = 1'b1;
    addr  = 4'd5;
    exp_q.push_back(12'hA05);
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    read_range(0, 15);

    do_load(1, 1'b0, 0, 1'b0, 4'd0);
    read_range(0, 15);

    do_load(0, 1'b1, 0, 1'b0, 4'd0);
    read_range(0, 15);

    do_load(2, 1'b0, 15, 1'b1, 4'd3);
    read_range(0, 7);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
